// File: rtl/lut_neuron_bank_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lut_neuron_bank_if: input/output valid-ready streams of lut_neuron_bank.
// Rev 1.0
// ----------------------------------------------------------------------------
interface lut_neuron_bank_if #(
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 2,
  parameter int NUM_NEURONS = 8
);
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_NEURONS*IN_BITS-1:0]  in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/lut_neuron_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lut_neuron_bank: time-multiplexed bank of run-time programmable LUT neurons.
// Optional LUT_INIT_CLEAR_EN zero-fills every table after reset.  Rev 1.0
// ----------------------------------------------------------------------------
module lut_neuron_bank #(
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 2,
  parameter int NUM_NEURONS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_NEURONS)-1:0] cfg_neuron,
  input  logic [IN_BITS-1:0]             cfg_addr,
  input  logic [OUT_BITS-1:0]            cfg_data,
  output logic                           cfg_err,
  output logic                           busy,
  lut_neuron_bank_if.slave               bus
);

  localparam int NW    = $clog2(NUM_NEURONS);
  localparam int DEPTH = 1 << IN_BITS;
  localparam int WORDS = NUM_NEURONS * DEPTH;
  localparam int AW    = $clog2(WORDS);
  localparam logic [NW-1:0] LAST_IDX = NW'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOOK  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3
`ifdef LUT_INIT_CLEAR_EN
    , CLEAR = 3'd4
`endif
  } state_t;

`ifdef LUT_INIT_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
  logic [AW-1:0] clr_cnt;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                          state;
  state_t                          state_nxt;
  logic                            armed;
  logic [NW-1:0]                   idx;
  logic [NUM_NEURONS*IN_BITS-1:0]  vec_q;
  logic [NUM_NEURONS*OUT_BITS-1:0] res_q;
  logic                            err_q;

  logic [OUT_BITS-1:0]             mem [WORDS];
  logic [OUT_BITS-1:0]             rd_data;
  logic                            mem_we;
  logic                            mem_re;
  logic [AW-1:0]                   mem_waddr;
  logic [AW-1:0]                   mem_raddr;
  logic [OUT_BITS-1:0]             mem_wdata;

  logic                            accept;
  logic                            cfg_ok;
  logic                            cap_en;
  logic [NW-1:0]                   cap_slot;

  // armed keeps in_ready low until the first edge after reset release
  assign bus.in_ready  = armed && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = res_q;
  assign busy          = (state != IDLE);
  assign cfg_err       = err_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign cfg_ok    = cfg_we && bus.in_ready && (int'(cfg_neuron) < NUM_NEURONS);
  assign mem_raddr = (AW'(idx) << IN_BITS) | AW'(vec_q[idx*IN_BITS +: IN_BITS]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = cfg_ok;
    mem_waddr = (AW'(cfg_neuron) << IN_BITS) | AW'(cfg_addr);
    mem_wdata = cfg_data;
    mem_re    = 1'b0;
    cap_en    = 1'b0;
    cap_slot  = idx - NW'(1);
    case (state)
      IDLE: begin
        if (accept) state_nxt = LOOK;
      end
      LOOK: begin
        // the word read at the previous edge belongs to slot idx-1
        mem_re = 1'b1;
        cap_en = (idx != '0);
        if (idx == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: begin
        cap_en    = 1'b1;
        cap_slot  = idx;
        state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
`ifdef LUT_INIT_CLEAR_EN
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
        if (clr_cnt == AW'(WORDS - 1)) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      idx   <= '0;
      vec_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      armed <= 1'b1;
      err_q <= cfg_we && !cfg_ok;
      if (accept) begin
        vec_q <= bus.in_data;
        idx   <= '0;
      end else if ((state == LOOK) && (idx != LAST_IDX)) begin
        idx <= idx + NW'(1);
      end
      if (cap_en) res_q[cap_slot*OUT_BITS +: OUT_BITS] <= rd_data;
    end
  end

`ifdef LUT_INIT_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + AW'(1);
    end
  end
`endif

  // table storage is deliberately not reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) rd_data <= mem[mem_raddr];
  end

endmodule
`default_nettype wire
